// File: rtl/reg_dump_reader.sv
// Walks a contiguous register-file address range and streams each value out
// as an (address, data) word over a valid/ready interface.
module reg_dump_reader #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W:0]   count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        LOAD = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               rd_en_d, out_valid_d, busy_d, done_d;
    logic [ADDR_W-1:0]  rd_addr_d, out_addr_d;
    logic [WIDTH-1:0]   out_data_d;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            rd_en       <= rd_en_d;
            rd_addr     <= rd_addr_d;
            out_valid   <= out_valid_d;
            out_data    <= out_data_d;
            out_addr    <= out_addr_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Next state; outputs are decoded from the state being entered so they
    // line up with that state once registered.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        rd_addr_d   = rd_addr;
        out_data_d  = out_data;
        out_addr_d  = out_addr;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        cur_addr_d  = first_addr;
                        remaining_d = count;
                        state_d     = REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            REQ: state_d = LOAD;
            LOAD: begin
                out_data_d = rd_data;
                out_addr_d = cur_addr_q;
                state_d    = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    remaining_d = CNT_W'(remaining_q - 1'b1);
                    cur_addr_d  = ADDR_W'(cur_addr_q + 1'b1);
                    state_d     = (remaining_q == CNT_W'(1)) ? DONE : REQ;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rd_en_d     = (state_d == REQ);
        out_valid_d = (state_d == SEND);
        busy_d      = (state_d == REQ) || (state_d == LOAD) || (state_d == SEND);
        done_d      = (state_d == DONE);
        if (state_d == REQ) begin
            rd_addr_d = cur_addr_d;
        end
    end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
Sequenced read-side engine for the CPU register file. On a start request it walks a contiguous range of register addresses and issues synchronous reads. It returns each value as an (address, data) word on a valid/ready output stream. Used for debug readout and context save. It sits between the register file read port and the debug/save consumer.

Parameters:
WIDTH, 8, data width of each register word
ADDR_W, 3, register address width (2^ADDR_W registers)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active high
start  input  1  begin a dump; sampled only in IDLE
first_addr  input  ADDR_W  first register address of the dump
count  input  ADDR_W+1  number of registers to read; 0 = no transfers
rd_en  output  1  read strobe to register file
rd_addr  output  ADDR_W  read address to register file
rd_data  input  WIDTH  register file read data, valid the cycle after rd_en
out_valid  output  1  output word valid
out_ready  input  1  consumer accepts word
out_data  output  WIDTH  captured register value
out_addr  output  ADDR_W  address out_data was read from
busy  output  1  high in REQ, LOAD, SEND
done  output  1  one-cycle pulse when a dump finishes

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. Asserting `rst` at any edge forces IDLE and drives all outputs to 0 on that edge: rd_en, rd_addr, out_valid, out_data, out_addr, busy, done. Internal address and remaining counters clear. A dump in progress is abandoned; no done pulse is produced.
- FSM states: IDLE, REQ, LOAD, SEND, DONE.
- IDLE:
  - start=1 with count!=0: latch cur_addr=first_addr and remaining=count, then go to REQ.
  - start=1 with count==0: go to DONE.
  - start=0: stay in IDLE.
- REQ: rd_en=1 and rd_addr=cur_addr for exactly one cycle. Go to LOAD.
- LOAD: rd_data is valid this cycle. On the edge, out_data<=rd_data, out_addr<=cur_addr and out_valid<=1. Go to SEND.
- SEND: out_valid=1. out_data and out_addr are held stable until handshake (out_valid && out_ready at an edge).
  - On handshake: out_valid<=0, remaining decrements, cur_addr<=cur_addr+1 modulo 2^ADDR_W (wraps to 0).
  - If remaining was 1, go to DONE; otherwise go to REQ.
  - Without handshake: stay in SEND.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE. start is ignored in DONE.
- start is ignored in every state except IDLE. first_addr and count are sampled only at the accepting edge.
- rd_en is 0 outside REQ. rd_addr holds its last value when rd_en=0.
- Latency: start sampled at edge of cycle 0 → rd_en in cycle 1 → out_valid in cycle 3. With out_ready held high, one word every 3 cycles. done is asserted the cycle after the final handshake.
- out_data and out_addr keep their last value after a dump until the next capture or reset.
- Counts larger than 2^ADDR_W are legal: addresses wrap and registers are re-read.

Test Plan:
1. Reset, then start with first_addr=2, count=3, register file preloaded r2=0xA5, r3=0x3C, r4=0xFF, out_ready=1 → words (2,0xA5), (3,0x3C), (4,0xFF); first out_valid in cycle 3 after start; done pulses one cycle after the third handshake; busy low afterwards.
2. Same dump with out_ready=0 for 5 cycles per word → out_valid stays high and out_data/out_addr are unchanged during stalls; no extra rd_en pulses; 3 words total.
3. first_addr=6, count=4, ADDR_W=3 → out_addr sequence 6, 7, 0, 1 with matching data.
4. start with count=0 → no rd_en, no out_valid; done pulses exactly one cycle after start; busy never high.
5. rst asserted in SEND of the 2nd word → next cycle all outputs 0 and state IDLE, no done pulse; a new start with first_addr=0, count=1 → single word (0, r0).
6. Pulse start again during REQ/SEND, and also during DONE → ignored; the transfer count and addresses match the original request only.
